// File: rtl/root_iter.sv
// Iterative floor square/cube root with remainder. Root bits are resolved
// MSB-first; each candidate power is built by a bit-serial shift-add multiply.
module root_iter #(
  parameter int W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [W-1:0]         a_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [(W+1)/2-1:0]   y_bo,
  output logic [W-1:0]         rem_bo
);
  localparam int OUT_W = (W + 1) / 2;
  localparam int NB_CU = (W + 2) / 3;
  localparam int SW    = 2 * OUT_W;
  localparam int AW    = 3 * OUT_W;
  localparam int CW    = $clog2(OUT_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SQ, CU, CMP, DONE} state_t;
  state_t state;

  logic [W-1:0]     a_r;
  logic             mode_r;
  logic [OUT_W-1:0] y_r;
  logic [AW-1:0]    p_r, pw_acc;
  logic [SW-1:0]    sq_acc;
  logic [CW-1:0]    b, cnt;

  logic [OUT_W-1:0] c, c_sh, y_nx;
  logic [SW-1:0]    sq_add;
  logic [AW-1:0]    cu_add, pw, a_ext, p_nx;
  logic             fit, last_cnt;

  // Full-width accumulators: an oversized candidate power simply compares
  // greater than the operand, no overflow detection needed.
  always_comb begin
    c        = y_r | (OUT_W'(1) << b);
    c_sh     = c >> cnt;
    sq_add   = c_sh[0] ? (SW'(c) << cnt) : '0;
    cu_add   = c_sh[0] ? (AW'(sq_acc) << cnt) : '0;
    pw       = mode_r ? pw_acc : AW'(sq_acc);
    a_ext    = AW'(a_r);
    fit      = (pw <= a_ext);
    y_nx     = fit ? c : y_r;
    p_nx     = fit ? pw : p_r;
    last_cnt = (cnt == CW'(OUT_W - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      y_bo   <= '0;
      rem_bo <= '0;
      a_r    <= '0;
      mode_r <= 1'b0;
      y_r    <= '0;
      p_r    <= '0;
      pw_acc <= '0;
      sq_acc <= '0;
      b      <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          a_r    <= a_bi;
          mode_r <= mode_i;
          busy_o <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          y_r    <= '0;
          p_r    <= '0;
          sq_acc <= '0;
          pw_acc <= '0;
          cnt    <= '0;
          b      <= mode_r ? CW'(NB_CU - 1) : CW'(OUT_W - 1);
          state  <= SQ;
        end
        SQ: begin
          sq_acc <= sq_acc + sq_add;
          cnt    <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt) begin
            pw_acc <= '0;
            state  <= mode_r ? CU : CMP;
          end
        end
        CU: begin
          pw_acc <= pw_acc + cu_add;
          cnt    <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt) state <= CMP;
        end
        CMP: begin
          y_r    <= y_nx;
          p_r    <= p_nx;
          sq_acc <= '0;
          if (b == '0) begin
            y_bo   <= y_nx;
            rem_bo <= W'(a_ext - p_nx);
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            b     <= b - 1'b1;
            state <= SQ;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_root_iter.sv
// Bench for root_iter at W=8 and W=16 against a timeline/arithmetic model.
module tb_root_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st[2], md[2];
  logic [15:0] ain[2];
  logic        busy[2], done[2];
  logic [15:0] yv[2], rv[2];

  logic b8, d8, b16, d16;
  logic [3:0]  y8;
  logic [7:0]  r8, y16;
  logic [15:0] r16;

  root_iter #(.W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(st[0]), .mode_i(md[0]), .a_bi(ain[0][7:0]),
    .busy_o(b8), .done_o(d8), .y_bo(y8), .rem_bo(r8));
  root_iter #(.W(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(st[1]), .mode_i(md[1]), .a_bi(ain[1]),
    .busy_o(b16), .done_o(d16), .y_bo(y16), .rem_bo(r16));

  always_comb begin
    busy[0] = b8;  done[0] = d8;  yv[0] = {12'd0, y8};  rv[0] = {8'd0, r8};
    busy[1] = b16; done[1] = d16; yv[1] = {8'd0, y16};  rv[1] = r16;
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endfunction

  function automatic longint pw(longint y, bit m);
    return m ? y * y * y : y * y;
  endfunction

  function automatic longint root_of(longint a, bit m);
    longint y = 0;
    while (pw(y + 1, m) <= a) y++;
    return y;
  endfunction

  function automatic int wid(int ch);
    return (ch != 0) ? 16 : 8;
  endfunction

  function automatic longint amask(int ch, logic [15:0] v);
    return (ch != 0) ? longint'(v) : longint'(v[7:0]);
  endfunction

  function automatic int lat(int w, bit m);
    int ow = (w + 1) / 2;
    int nb = m ? (w + 2) / 3 : ow;
    int p  = m ? 2 * ow + 1 : ow + 1;
    return 2 + nb * p;
  endfunction

  // Model: a run is a timeline of lat() cycles after the accepting edge.
  bit     live = 1'b0;
  int     cyc  = 0;
  bit     m_busy[2], m_done[2], m_mode[2];
  int     m_ph[2], m_lat[2];
  longint m_a[2], m_ny[2], m_y[2], m_r[2];

  always @(posedge clk) begin
    live <= 1'b1;
    cyc  <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_y[i] <= 0; m_r[i] <= 0; m_ph[i] <= 0;
      end else if (!m_busy[i]) begin
        m_done[i] <= 1'b0;
        if (st[i]) begin
          m_busy[i] <= 1'b1;
          m_ph[i]   <= 1;
          m_mode[i] <= md[i];
          m_lat[i]  <= lat(wid(i), md[i]);
          m_a[i]    <= amask(i, ain[i]);
          m_ny[i]   <= root_of(amask(i, ain[i]), md[i]);
        end
      end else begin
        m_ph[i]   <= m_ph[i] + 1;
        m_done[i] <= (m_ph[i] + 1 == m_lat[i]);
        if (m_ph[i] + 1 == m_lat[i]) begin
          m_y[i] <= m_ny[i];
          m_r[i] <= m_a[i] - pw(m_ny[i], m_mode[i]);
        end
        if (m_ph[i] == m_lat[i]) m_busy[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        chk(i ? "busy16" : "busy8", busy[i], m_busy[i]);
        chk(i ? "done16" : "done8", done[i], m_done[i]);
        chk(i ? "y16" : "y8", yv[i], m_y[i]);
        chk(i ? "rem16" : "rem8", rv[i], m_r[i]);
        if (done[i]) chk(i ? "ident16" : "ident8", pw(yv[i], m_mode[i]) + rv[i], m_a[i]);
      end
    end
  end

  // One run; optionally pokes a start with a=8 at cycle 'poke' of the run.
  task automatic go(input int ch, input int a, input bit m, input int poke,
                    output longint ry, output longint rr, output int lc);
    @(negedge clk);
    st[ch] = 1'b1; ain[ch] = 16'(a); md[ch] = m;
    @(negedge clk);
    st[ch] = 1'b0;
    lc = 1;
    while (!done[ch] && lc < 400) begin
      if (lc == poke) begin st[ch] = 1'b1; ain[ch] = 16'd8; end
      else begin st[ch] = 1'b0; ain[ch] = 16'($urandom); md[ch] = 1'($urandom); end
      @(negedge clk);
      lc++;
    end
    st[ch] = 1'b0;
    chk("done_seen", done[ch], 1);
    ry = yv[ch];
    rr = rv[ch];
    @(negedge clk);
  endtask

  typedef struct { int ch; int a; bit m; int ey; int er; int el; } vec_t;
  vec_t dir[8] = '{
    '{0, 200,   0, 14,  4,    22},
    '{0, 255,   0, 15,  30,   22},
    '{0, 0,     0, 0,   0,    22},
    '{0, 125,   1, 5,   0,    29},
    '{0, 255,   1, 6,   39,   29},
    '{0, 7,     1, 1,   6,    29},
    '{1, 65535, 0, 255, 510,  74},
    '{1, 65535, 1, 40,  1535, 104}
  };

  initial begin
    longint ry, rr;
    int lc, nd, t0, t1, t2, k;
    st = '{1'b0, 1'b0}; md = '{1'b0, 1'b0}; ain = '{16'd0, 16'd0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_y", yv[1], 0);
    chk("rst_rem", rv[0], 0);
    chk("rst_done", done[1], 0);
    rst = 1'b0;

    foreach (dir[i]) begin
      go(dir[i].ch, dir[i].a, dir[i].m, -1, ry, rr, lc);
      chk("dir_y", ry, dir[i].ey);
      chk("dir_rem", rr, dir[i].er);
      chk("dir_lat", lc, dir[i].el);
    end

    // start while busy: only the first operand's result, single done
    go(0, 100, 1'b0, 6, ry, rr, lc);
    chk("busy_start_y", ry, 10);
    chk("busy_start_rem", rr, 0);
    chk("busy_start_lat", lc, 22);
    nd = 0;
    repeat (30) begin @(negedge clk); if (done[0]) nd++; end
    chk("busy_start_extra_done", nd, 0);

    // reset mid cube run
    @(negedge clk);
    st[0] = 1'b1; ain[0] = 16'd200; md[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_y", yv[0], 0);
    chk("rst_mid_rem", rv[0], 0);
    nd = 0;
    repeat (30) begin @(negedge clk); if (done[0]) nd++; end
    chk("rst_mid_done", nd, 0);
    go(0, 200, 1'b1, -1, ry, rr, lc);
    chk("after_rst_y", ry, 5);
    chk("after_rst_rem", rr, 75);

    // back-to-back with start held high
    @(negedge clk);
    st[0] = 1'b1; ain[0] = 16'd50; md[0] = 1'b0;
    nd = 0; k = 0; t0 = 0; t1 = 0; t2 = 0;
    while (nd < 3 && k < 200) begin
      @(negedge clk);
      k++;
      if (done[0]) begin
        if (nd == 0) t0 = k; else if (nd == 1) t1 = k; else t2 = k;
        nd++;
        chk("b2b_y", yv[0], 7);
      end
    end
    st[0] = 1'b0;
    chk("b2b_count", nd, 3);
    chk("b2b_gap1", t1 - t0, 23);
    chk("b2b_gap2", t2 - t1, 23);
    k = 0;
    while (busy[0] && k < 100) begin @(negedge clk); k++; end
    chk("b2b_drain", busy[0], 0);

    // exhaustive W=8
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 256; a++) begin
        go(0, a, m[0], -1, ry, rr, lc);
        chk("sweep_lat", lc, m ? 29 : 22);
      end

    // randomized runs on both widths
    repeat (60) begin
      k = $urandom_range(1);
      go(k, int'($urandom_range(65535)), 1'($urandom), int'($urandom_range(40)), ry, rr, lc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/root_iter.md
# root_iter

Parametrised iterative integer root unit: computes floor(a^(1/k)) and remainder for k = 2 (square root) or k = 3 (cube root) on an unsigned W-bit operand. Result bits are found MSB-first by binary search, and candidate powers are formed with an internal shift-add multiplier, so no external multiplier instance is needed. It sits beside the existing arithmetic units as their generalised successor. It adds an explicit start/done handshake, a runtime mode select, and a remainder output.

## Interface
- W, 8: operand width. Legal range 2..32.
- OUT_W (localparam), ceil(W/2): result width. It is sized for square root and is also used for cube root.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = square root, 1 = cube root; sampled with start_i.
- a_bi  in  W  unsigned operand; sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when y_bo/rem_bo update.
- y_bo  out  OUT_W  floor root, zero-extended.
- rem_bo  out  W  a - y^k.

## Operation
- States:
  - IDLE -> LOAD on start_i.
  - LOAD -> SQ.
  - SQ (OUT_W cycles) -> CU if mode = cube, otherwise CMP.
  - CU (OUT_W cycles) -> CMP.
  - CMP -> SQ if bits remain, otherwise DONE.
  - DONE -> IDLE.
- Bit count NB: OUT_W for square, ceil(W/3) for cube. The search starts at bit NB-1.
- LOAD:
  - Latch a, mode.
  - Clear the partial root y_r and best power p_r.
  - Set bit index b = NB-1.
- Each bit forms candidate c = y_r | (1<<b).
- SQ: sq = c*c by shift-add. One multiplier bit per cycle, LSB first, 2*OUT_W-bit accumulator.
- CU: pw = sq*c by shift-add, 3*OUT_W-bit accumulator. In square mode pw = sq, zero-extended.
- CMP:
  - If pw <= a (a zero-extended to 3*OUT_W bits): y_r <= c, p_r <= pw.
  - Then b decrements.
  - Widths are never truncated before the comparison, so overflowing candidates always compare greater than a.
- DONE:
  - y_bo <= y_r; rem_bo <= a - p_r (fits in W bits, never negative).
  - done_o = 1.
- y_bo and rem_bo hold their values until the next DONE or reset.
- start_i while busy_o = 1 is ignored, not queued. a_bi and mode_i may change freely while busy.

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, y_bo 0, rem_bo 0, internal registers 0.
- rst_i high in any state aborts the operation on the next edge. Outputs are cleared and no done_o is generated.
- rst_i and start_i high together: reset wins and the start is dropped.
- Let E0 be the edge that samples start_i in IDLE. busy_o is high from the cycle after E0.
- done_o is high in cycle 2 + NB*P after E0.
  - P = OUT_W + 1 for square root.
  - P = 2*OUT_W + 1 for cube root.
- Latency is fixed and independent of operand value.
- W = 8:
  - square root 22 cycles
  - cube root 29 cycles
- W = 16:
  - square root 74 cycles
  - cube root 104 cycles
- busy_o is still high during the DONE cycle. The earliest next start is sampled on the edge after the DONE cycle, when busy_o = 0 in IDLE.
- done_o is never asserted for two consecutive cycles.

## Test plan
- W=8, mode 0, a=200 -> done_o at cycle 22, y_bo=14, rem_bo=4. Also a=255 -> 15/30 and a=0 -> 0/0.
- W=8, mode 1:
  - a=125 -> y_bo=5, rem_bo=0, done_o at cycle 29.
  - a=255 -> 6/39.
  - a=7 -> 1/6.
- W=16:
  - mode 0, a=65535 -> 255/510.
  - mode 1, a=65535 -> 40/1535 at cycle 104. This exercises the overflow compare, since 63^3 > a.
- Start while busy: a second start_i with a=8 mid-run -> ignored. Only one done_o, carrying the first operand's result, and a_bi changes during the run have no effect.
- Reset mid-run: rst_i pulsed at cycle 10 of a cube-root run -> next cycle busy_o=0, y_bo=0, rem_bo=0, no done_o. A new start then completes normally.
- Back-to-back: start held high continuously -> a new run begins one cycle after each DONE, and done_o pulses are separated by exactly the latency + 1 cycles.
- Exhaustive sweep, W=8: all 256 operands in both modes, checked against a model floor root with y^k + rem = a.
